mem_access_unit: RTL and testbench

- Load/store controller between the pipeline's memory stage and the synchronous byte-enabled `RAM`.
- Accepts one load or store per request over a valid/ready handshake.
- Drives the RAM port: word-aligned address, 4-bit byte enables, lane-positioned write data.
- Returns load data sign- or zero-extended, with a completion response for every request.

---
 rtl/mem_access_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store controller sitting between the pipeline memory stage and a
// synchronous, byte-enabled RAM. One request is accepted at a time and every
// request produces exactly one completion response.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. The producer holds its payload stable while valid is high
// and ready is low. req_ready depends on FSM state only. resp_valid, once
// raised, stays high with stable resp_rdata/resp_error until resp_ready.
//
// Optional build macro: MEM_ACCESS_ALIGN_CHECK_EN
//   defined   - misaligned halfword/word requests bypass the RAM and are
//               answered with resp_error = 1, resp_rdata = 0.
//   undefined - no alignment check; halfwords ignore addr[0], words ignore
//               addr[1:0]; resp_error is tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_op            0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_error        misaligned access flag
//   ram_en            RAM enable (ACCESS state only)
//   ram_write_en      byte write enables, bit i = lane i
//   ram_addr          word-aligned RAM address
//   ram_write_data    lane-positioned store data
//   ram_read_data     RAM read data, valid the cycle after a read enable
// -----------------------------------------------------------------------------
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    // RESP is split in two phases: the first cycle captures the RAM read
    // data (or settles the error), the response is only offered once
    // valid_q is set. This keeps resp_rdata purely registered.
    logic        valid_q, valid_d;

    logic        req_misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // -------------------------------------------------------------------------
    // Alignment check on the incoming request
    // -------------------------------------------------------------------------
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    always_comb begin
        req_misaligned = 1'b0;
        case (req_op)
            OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
            OP_LW, OP_SW:         req_misaligned = (req_addr[1:0] != 2'b00);
            default:              req_misaligned = 1'b0;
        endcase
    end
`else
    assign req_misaligned = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Load lane selection and extension (little-endian lanes)
    // -------------------------------------------------------------------------
    always_comb begin
        byte_sel = ram_read_data[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = ram_read_data[7:0];
            2'd1: byte_sel = ram_read_data[15:8];
            2'd2: byte_sel = ram_read_data[23:16];
            2'd3: byte_sel = ram_read_data[31:24];
            default: byte_sel = ram_read_data[7:0];
        endcase
        // addr[0] is deliberately ignored for halfwords.
        half_sel = addr_q[1] ? ram_read_data[31:16] : ram_read_data[15:0];
    end

    always_comb begin
        load_data = 32'd0;
        case (op_q)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            OP_LW:   load_data = ram_read_data;
            default: load_data = 32'd0;  // stores return zero
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = req_misaligned;
                    valid_d = 1'b0;
                    // A misaligned request never touches the RAM.
                    state_d = req_misaligned ? S_RESP : S_ACCESS;
                end
            end

            S_ACCESS: begin
                state_d = S_RESP;
            end

            S_RESP: begin
                if (!valid_q) begin
                    // Capture phase: RAM data for the access is on
                    // ram_read_data now.
                    valid_d = 1'b1;
                    rdata_d = err_q ? 32'd0 : load_data;
                end else if (resp_ready) begin
                    valid_d = 1'b0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign resp_error = valid_q & err_q;
`else
    assign resp_error = 1'b0;
`endif

    // RAM port is active only in ACCESS; because it decodes state_q, an
    // asynchronous reset drops an in-flight write immediately.
    always_comb begin
        ram_en         = 1'b0;
        ram_write_en   = 4'b0000;
        ram_addr       = 32'd0;
        ram_write_data = 32'd0;
        if (state_q == S_ACCESS) begin
            ram_en   = 1'b1;
            ram_addr = {addr_q[31:2], 2'b00};
            case (op_q)
                OP_SB: begin
                    ram_write_en   = 4'b0001 << addr_q[1:0];
                    ram_write_data = {4{wdata_q[7:0]}};
                end
                OP_SH: begin
                    ram_write_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                    ram_write_data = {2{wdata_q[15:0]}};
                end
                OP_SW: begin
                    ram_write_en   = 4'b1111;
                    ram_write_data = wdata_q;
                end
                default: begin
                    ram_write_en   = 4'b0000;
                    ram_write_data = 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// Bench for mem_access_unit: a byte-array golden memory drives the expected
// response of each request, a simple synchronous RAM answers the DUT's RAM
// port, and one negedge compare process checks every output each cycle
// against the expectation set for that cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3;
    localparam logic [2:0] LW = 3'd4, SB  = 3'd5, SH = 3'd6, SW  = 3'd7;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, resp_valid, resp_ready, resp_error;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data;
    logic [31:0] ram_read_data;

    mem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    // ---------------- RAM attached to the DUT ----------------
    logic [31:0] ram_words [0:15];
    initial ram_read_data = 32'd0;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_read_data <= ram_words[ram_addr[5:2]];
            for (int i = 0; i < 4; i++)
                if (ram_write_en[i])
                    ram_words[ram_addr[5:2]][8*i +: 8] <= ram_write_data[8*i +: 8];
        end
    end

    // ---------------- golden model ----------------
    logic [7:0] gmem [0:63];

    function automatic bit model_mis(logic [2:0] op, logic [31:0] a);
        if (!ALIGN) return 1'b0;
        case (op)
            LH, LHU, SH: return a[0];
            LW, SW:      return a[1:0] != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] op, logic [31:0] a);
        int b, hb, wb;
        logic [15:0] h;
        b  = int'(a & 32'd63);
        hb = b & ~1;
        wb = b & ~3;
        h  = {gmem[hb+1], gmem[hb]};
        case (op)
            LB:      return {{24{gmem[b][7]}}, gmem[b]};
            LBU:     return {24'd0, gmem[b]};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'd0, h};
            LW:      return {gmem[wb+3], gmem[wb+2], gmem[wb+1], gmem[wb]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(logic [2:0] op, logic [31:0] a, logic [31:0] w);
        int b, hb, wb;
        b  = int'(a & 32'd63);
        hb = b & ~1;
        wb = b & ~3;
        case (op)
            SB: gmem[b] = w[7:0];
            SH: begin gmem[hb] = w[7:0]; gmem[hb+1] = w[15:8]; end
            SW: for (int i = 0; i < 4; i++) gmem[wb+i] = w[8*i +: 8];
            default: ;
        endcase
    endtask

    function automatic logic [3:0] model_we(logic [2:0] op, logic [31:0] a);
        case (op)
            SB:      return 4'b0001 << (a & 32'd3);
            SH:      return 4'b0011 << (a & 32'd2);
            SW:      return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(logic [2:0] op, logic [31:0] w);
        case (op)
            SB:      return {4{w[7:0]}};
            SH:      return {2{w[15:0]}};
            SW:      return w;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    endtask

    // expectations for the current cycle
    bit          chk_en = 1'b0;
    logic        e_req_ready, e_resp_valid, e_resp_error, e_ram_en;
    logic [31:0] e_resp_rdata, e_ram_addr, e_ram_wd;
    logic [3:0]  e_ram_we;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",      {31'd0, req_ready},    {31'd0, e_req_ready});
            check("resp_valid",     {31'd0, resp_valid},   {31'd0, e_resp_valid});
            check("ram_en",         {31'd0, ram_en},       {31'd0, e_ram_en});
            check("ram_write_en",   {28'd0, ram_write_en}, {28'd0, e_ram_we});
            check("ram_addr",       ram_addr,              e_ram_addr);
            check("ram_write_data", ram_write_data,        e_ram_wd);
            if (e_resp_valid) begin
                check("resp_rdata", resp_rdata,            e_resp_rdata);
                check("resp_error", {31'd0, resp_error},   {31'd0, e_resp_error});
            end
        end
    end

    task automatic exp_quiet(logic rdy);
        e_req_ready  = rdy;
        e_resp_valid = 1'b0;
        e_resp_error = 1'b0;
        e_resp_rdata = 32'd0;
        e_ram_en     = 1'b0;
        e_ram_we     = 4'd0;
        e_ram_addr   = 32'd0;
        e_ram_wd     = 32'd0;
    endtask

    // ---------------- driver tasks ----------------
    // Random request-side noise while the unit is busy; it must be ignored.
    task automatic junk();
        req_valid  = 1'($urandom_range(0, 1));
        req_op     = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        resp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) begin
            req_valid  = 1'b0;
            resp_ready = 1'($urandom_range(0, 1));
            exp_quiet(1'b1);
            @(posedge clk); #1;
        end
    endtask

    // Issues one request starting in IDLE (called at posedge+1). Returns the
    // values seen on the DUT during ACCESS and the response cycle.
    task automatic do_req(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] w, input int hold,
                          output logic [31:0] got_rdata, output logic got_err,
                          output logic [3:0] got_we, output logic [31:0] got_wd);
        bit          mis;
        logic [31:0] exp_ld;
        got_we = 4'd0;
        got_wd = 32'd0;
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = a;
        req_wdata  = w;
        resp_ready = 1'($urandom_range(0, 1));
        exp_quiet(1'b1);
        @(posedge clk); #1;

        mis    = model_mis(op, a);
        exp_ld = mis ? 32'd0 : model_load(op, a);
        junk();
        if (!mis) begin
            exp_quiet(1'b0);
            e_ram_en   = 1'b1;
            e_ram_we   = model_we(op, a);
            e_ram_addr = {a[31:2], 2'b00};
            e_ram_wd   = model_wd(op, w);
            got_we = ram_write_en;
            got_wd = ram_write_data;
            model_store(op, a, w);
            @(posedge clk); #1;
            junk();
        end
        exp_quiet(1'b0);                 // capture cycle: nothing offered yet
        @(posedge clk); #1;
        for (int h = 0; h <= hold; h++) begin
            junk();
            resp_ready   = (h == hold);
            exp_quiet(1'b0);
            e_resp_valid = 1'b1;
            e_resp_rdata = exp_ld;
            e_resp_error = mis;
            got_rdata    = resp_rdata;
            got_err      = resp_error;
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        exp_quiet(1'b1);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] rd, wd;
    logic        er;
    logic [3:0]  we;

    initial begin
        for (int i = 0; i < 64; i++) gmem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++)
            ram_words[i] = {gmem[4*i+3], gmem[4*i+2], gmem[4*i+1], gmem[4*i]};
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; resp_ready = 1'b0;
        #2;
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_error", {31'd0, resp_error}, 32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_ram_en",     {31'd0, ram_en},     32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_quiet(1'b1);
        chk_en = 1'b1;
        idle_cycles(2);

        // directed sequence with literal expectations
        do_req(SW, 32'h0, 32'h12345678, 0, rd, er, we, wd);
        check("sw_we", {28'd0, we}, 32'hF);
        check("sw_wd", wd, 32'h12345678);
        do_req(LW, 32'h0, 32'h0, 0, rd, er, we, wd);
        check("lw0", rd, 32'h12345678);
        do_req(SB, 32'h1, 32'h000000EF, 0, rd, er, we, wd);
        check("sb_we", {28'd0, we}, 32'h2);
        check("sb_wd", wd, 32'hEFEFEFEF);
        do_req(LW, 32'h0, 32'h0, 0, rd, er, we, wd);
        check("lw0_after_sb", rd, 32'h1234EF78);
        do_req(LB, 32'h1, 32'h0, 0, rd, er, we, wd);
        check("lb1", rd, 32'hFFFFFFEF);
        do_req(LBU, 32'h1, 32'h0, 0, rd, er, we, wd);
        check("lbu1", rd, 32'h000000EF);
        do_req(LH, 32'h2, 32'h0, 0, rd, er, we, wd);
        check("lh2", rd, 32'h00001234);
        do_req(LHU, 32'h0, 32'h0, 0, rd, er, we, wd);
        check("lhu0", rd, 32'h0000EF78);
        do_req(LW, 32'h2, 32'h0, 0, rd, er, we, wd);
        check("lw2_err",   {31'd0, er}, {31'd0, ALIGN});
        check("lw2_rdata", rd, ALIGN ? 32'h0 : 32'h1234EF78);

        // back-pressure: response held for 5 cycles
        do_req(LBU, 32'h3, 32'h0, 5, rd, er, we, wd);
        check("lbu3_held", rd, 32'h00000012);

        // reset during ACCESS of a store
        do_req(SW, 32'h8, 32'h0BADF00D, 0, rd, er, we, wd);
        idle_cycles(1);
        req_valid = 1'b1; req_op = SW; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk_en = 1'b0;
        check("pre_rst_ram_en", {31'd0, ram_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ram_en", {31'd0, ram_en},       32'd0);
        check("async_rst_we",     {28'd0, ram_write_en}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        exp_quiet(1'b1);
        chk_en = 1'b1;
        idle_cycles(1);
        do_req(LW, 32'h8, 32'h0, 0, rd, er, we, wd);
        check("lw8_after_rst", rd, 32'h0BADF00D);

        // randomized traffic against the golden memory
        for (int n = 0; n < 200; n++) begin
            idle_cycles($urandom_range(0, 2));
            do_req(3'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                   rd, er, we, wd);
        end
        idle_cycles(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
